// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants and helpers for the MDIO management master.
//   - ST/OP field encodings for Clause 22 and Clause 45 frames
//   - state encoding of the master FSM
//   - bit positions of the fields inside the 32-bit management frame
//   - frame classification helpers (legality, read vs write/address)
package mdio_pkg;

  // Start-of-frame codes
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  // Opcodes
  localparam logic [1:0] OP_WR       = 2'b01;
  localparam logic [1:0] OP_RD       = 2'b10;
  localparam logic [1:0] OP_C45_ADDR = 2'b00;
  localparam logic [1:0] OP_C45_RD   = 2'b11;
  localparam logic [1:0] OP_C45_PRD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    FRAME = 2'd2
  } state_t;

  // Frame field bit positions
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // Bit-counter landmarks inside the FRAME phase (counter = current bit index)
  localparam logic [5:0] FRAME_LAST_BIT = 6'd31;
  localparam logic [5:0] OE_RELEASE_BIT = 6'd17;
  localparam logic [5:0] TA_SAMPLE_BIT  = 6'd16;

  // ST=01 is always legal; ST=00 only when Clause 45 is enabled; ST=1x never.
  function automatic logic frame_legal(input logic [1:0] st, input logic c45_en);
    return (st == ST_C22) || (c45_en && (st == ST_C45));
  endfunction

  // Reads hand the bus to the PHY after the register address.
  function automatic logic frame_is_read(input logic [1:0] st, input logic [1:0] op,
                                         input logic c45_en);
    return ((st == ST_C22) && (op == OP_RD)) ||
           (c45_en && (st == ST_C45) && ((op == OP_C45_RD) || (op == OP_C45_PRD)));
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC divider for the MDIO master.
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   en      in   transaction in progress; when low the divider is held at the
//                start of a bit with MDC low
//   mdc     out  management clock, low for the first CLK_DIV cycles of a bit
//   sample  out  strobe in the cycle whose closing edge raises MDC
//   bit_end out  strobe in the last cycle of a bit (closing edge drops MDC)
module mdio_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic sample,
  output logic bit_end
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap    = en && (div_cnt == DIV_LAST);
  // The MDC register doubles as the half-bit phase flag.
  assign sample  = wrap && !mdc;
  assign bit_end = wrap && mdc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_param.sv
// mdio_master_param: single-channel IEEE 802.3 MDIO management master.
// Sends an optional preamble of '1' bits followed by the 32-bit frame in
// T_DATA (MSB first), turning the pad around for read frames and capturing
// the 16 read-data bits from the PHY.
//   CLK        in   system clock
//   RESET      in   asynchronous active-low reset
//   MDIO_START in   request, only looked at while idle
//   T_DATA     in   frame {ST, OP, PHYAD, REGAD, TA, DATA}, latched on accept
//   MDIO_IN    in   pad input
//   MDC        out  management clock
//   MDIO_OUT   out  serial data to the pad
//   MDIO_OE    out  pad output enable
//   RD_DATA    out  last captured read data (updated at read completion)
//   DATA_RDY   out  1-cycle pulse with RD_DATA update
//   DONE       out  1-cycle pulse at the end of every transaction
//   BUSY       out  transaction in progress
//   ERR        out  sticky error (bad turnaround or illegal frame)
module mdio_master_param
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32,
  parameter int C45_EN  = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        DONE,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic       C45_OK   = (C45_EN != 0);
  localparam logic [5:0] PRE_LOAD = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

  state_t      state;
  logic [31:0] frame;      // shifts left; bit 31 is always the next bit to send
  logic        is_read;
  logic [5:0]  bit_cnt;    // index of the bit currently on the wire
  logic [5:0]  bit_cnt_dec;
  logic [15:0] rx_shift;
  logic        sample;
  logic        bit_end;
  logic        start_legal;
  logic        start_read;

  assign start_legal = frame_legal(T_DATA[ST_MSB:ST_LSB], C45_OK);
  assign start_read  = frame_is_read(T_DATA[ST_MSB:ST_LSB], T_DATA[OP_MSB:OP_LSB], C45_OK);
  assign bit_cnt_dec = bit_cnt - 6'd1;

  mdio_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (CLK),
    .rst_n   (RESET),
    .en      (BUSY),
    .mdc     (MDC),
    .sample  (sample),
    .bit_end (bit_end)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      frame    <= '0;
      is_read  <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      DATA_RDY <= 1'b0;
      case (state)
        IDLE: begin
          if (MDIO_START) begin
            if (start_legal) begin
              is_read <= start_read;
              ERR     <= 1'b0;
              BUSY    <= 1'b1;
              MDIO_OE <= 1'b1;
              if (PRE_LEN > 0) begin
                state    <= PRE;
                bit_cnt  <= PRE_LOAD;
                frame    <= T_DATA;
                MDIO_OUT <= 1'b1;
              end else begin
                // First frame bit goes out now, so the shifter starts one bit on.
                state    <= FRAME;
                bit_cnt  <= FRAME_LAST_BIT;
                frame    <= {T_DATA[30:0], 1'b0};
                MDIO_OUT <= T_DATA[31];
              end
            end else begin
              // Rejected frame: report and stay idle without touching the bus.
              ERR  <= 1'b1;
              DONE <= 1'b1;
            end
          end
        end

        PRE: begin
          if (bit_end) begin
            if (bit_cnt == 6'd0) begin
              state    <= FRAME;
              bit_cnt  <= FRAME_LAST_BIT;
              MDIO_OUT <= frame[31];
              frame    <= {frame[30:0], 1'b0};
            end else begin
              bit_cnt <= bit_cnt_dec;
            end
          end
        end

        FRAME: begin
          if (sample && is_read) begin
            // Second TA bit must be driven low by the PHY.
            if ((bit_cnt == TA_SAMPLE_BIT) && MDIO_IN) begin
              ERR <= 1'b1;
            end
            if (bit_cnt < TA_SAMPLE_BIT) begin
              rx_shift <= {rx_shift[14:0], MDIO_IN};
            end
          end
          if (bit_end) begin
            if (bit_cnt == 6'd0) begin
              state    <= IDLE;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              MDIO_OE  <= 1'b0;
              MDIO_OUT <= 1'b0;
              if (is_read) begin
                RD_DATA  <= rx_shift;
                DATA_RDY <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt_dec;
              frame   <= {frame[30:0], 1'b0};
              if (is_read && (bit_cnt_dec <= OE_RELEASE_BIT)) begin
                MDIO_OE  <= 1'b0;
                MDIO_OUT <= 1'b0;
              end else begin
                MDIO_OUT <= frame[31];
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_param.sv
// tb_mdio_master_param: directed bench for mdio_master_param.
// Three instances share one clock:
//   dut_a  CLK_DIV=2, PRE_LEN=32, C45_EN=1
//   dut_b  CLK_DIV=2, PRE_LEN=32, C45_EN=0
//   dut_c  CLK_DIV=2, PRE_LEN=0,  C45_EN=1
module tb_mdio_master_param;

  localparam int BIT_CYC = 4;  // 2*CLK_DIV

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        a_rst_n, a_start, a_in, a_mdc, a_out, a_oe, a_rdy, a_done, a_busy, a_err;
  logic [31:0] a_tdata;
  logic [15:0] a_rd;
  logic        b_rst_n, b_start, b_in, b_mdc, b_out, b_oe, b_rdy, b_done, b_busy, b_err;
  logic [31:0] b_tdata;
  logic [15:0] b_rd;
  logic        c_rst_n, c_start, c_in, c_mdc, c_out, c_oe, c_rdy, c_done, c_busy, c_err;
  logic [31:0] c_tdata;
  logic [15:0] c_rd;

  mdio_master_param #(.CLK_DIV(2), .PRE_LEN(32), .C45_EN(1)) dut_a (
    .CLK(clk), .RESET(a_rst_n), .MDIO_START(a_start), .T_DATA(a_tdata), .MDIO_IN(a_in),
    .MDC(a_mdc), .MDIO_OUT(a_out), .MDIO_OE(a_oe), .RD_DATA(a_rd), .DATA_RDY(a_rdy),
    .DONE(a_done), .BUSY(a_busy), .ERR(a_err));

  mdio_master_param #(.CLK_DIV(2), .PRE_LEN(32), .C45_EN(0)) dut_b (
    .CLK(clk), .RESET(b_rst_n), .MDIO_START(b_start), .T_DATA(b_tdata), .MDIO_IN(b_in),
    .MDC(b_mdc), .MDIO_OUT(b_out), .MDIO_OE(b_oe), .RD_DATA(b_rd), .DATA_RDY(b_rdy),
    .DONE(b_done), .BUSY(b_busy), .ERR(b_err));

  mdio_master_param #(.CLK_DIV(2), .PRE_LEN(0), .C45_EN(1)) dut_c (
    .CLK(clk), .RESET(c_rst_n), .MDIO_START(c_start), .T_DATA(c_tdata), .MDIO_IN(c_in),
    .MDC(c_mdc), .MDIO_OUT(c_out), .MDIO_OE(c_oe), .RD_DATA(c_rd), .DATA_RDY(c_rdy),
    .DONE(c_done), .BUSY(c_busy), .ERR(c_err));

  typedef struct {
    logic [63:0] obits;
    logic [63:0] oebits;
    int          done_at;
    int          done_cnt;
    int          rdy_cnt;
    int          mdc_bad;
    int          busy_bad;
    logic [15:0] rd_done;
    logic        err_done;
    logic        err_first;
    logic        busy_done;
    logic        mdc_done;
    logic        oe_done;
  } obs_t;

  // Runs one full transaction on dut_a, acting as the PHY for read frames,
  // and records what the master put on the wire (first bit in obits[63]).
  task automatic run_a(input logic [31:0] td, input logic [15:0] rdat, input logic ta,
                       output obs_t o);
    o.obits = '0; o.oebits = '0; o.done_at = -1; o.done_cnt = 0; o.rdy_cnt = 0;
    o.mdc_bad = 0; o.busy_bad = 0; o.rd_done = '0; o.err_done = 1'b0; o.err_first = 1'b0;
    o.busy_done = 1'b0; o.mdc_done = 1'b0; o.oe_done = 1'b0;
    @(negedge clk);
    a_tdata = td;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int cyc = 1; cyc <= 262; cyc++) begin
      if (cyc == 1) o.err_first = a_err;
      if (cyc <= 64 * BIT_CYC) begin
        int j;
        int ph;
        int b;
        j  = (cyc - 1) / BIT_CYC;
        ph = (cyc - 1) % BIT_CYC;
        b  = 63 - j;
        if (ph == 0) begin
          o.obits[63 - j]  = a_out;
          o.oebits[63 - j] = a_oe;
          if (j < 32 || b > 16) a_in = 1'b1;
          else if (b == 16)     a_in = ta;
          else                  a_in = rdat[b];
        end
        if (a_mdc !== (ph >= 2)) o.mdc_bad++;
        if (a_busy !== 1'b1) o.busy_bad++;
      end
      if (a_done === 1'b1) begin
        o.done_cnt++;
        if (o.done_at < 0) begin
          o.done_at   = cyc;
          o.rd_done   = a_rd;
          o.err_done  = a_err;
          o.busy_done = a_busy;
          o.mdc_done  = a_mdc;
          o.oe_done   = a_oe;
        end
      end
      if (a_rdy === 1'b1) o.rdy_cnt++;
      @(posedge clk); #1;
    end
    a_in = 1'b1;
    $display("[TB] txn T_DATA=%08h done_at=%0d rd=%04h err=%0b", td, o.done_at, o.rd_done, o.err_done);
  endtask

  task automatic test_reset();
    // Still inside reset here.
    tests_run++;
    if ({a_mdc, a_out, a_oe, a_rdy, a_done, a_busy, a_err} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 0000000", {a_mdc, a_out, a_oe, a_rdy, a_done, a_busy, a_err});
    end
    tests_run++;
    if (a_rd !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_rd: got %h want 0000", a_rd);
    end
    tests_run++;
    if ({b_busy, b_err, c_busy, c_mdc} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_bc: got %b want 0000", {b_busy, b_err, c_busy, c_mdc});
    end
  endtask

  task automatic test_c22_write();
    obs_t o;
    run_a(32'h5192_BEEF, 16'h0000, 1'b0, o);
    tests_run++;
    if (o.obits !== {32'hFFFF_FFFF, 32'h5192_BEEF}) begin
      tests_failed++; $display("FAIL wr_stream: got %h want ffffffff5192beef", o.obits);
    end
    tests_run++;
    if (o.oebits !== {64{1'b1}}) begin
      tests_failed++; $display("FAIL wr_oe: got %h want ffffffffffffffff", o.oebits);
    end
    tests_run++;
    if (o.done_at !== 257 || o.done_cnt !== 1) begin
      tests_failed++; $display("FAIL wr_done: got at %0d cnt %0d want at 257 cnt 1", o.done_at, o.done_cnt);
    end
    tests_run++;
    if (o.rdy_cnt !== 0 || o.err_done !== 1'b0) begin
      tests_failed++; $display("FAIL wr_rdy_err: got rdy %0d err %b want 0 0", o.rdy_cnt, o.err_done);
    end
    tests_run++;
    if (o.mdc_bad !== 0 || o.busy_bad !== 0) begin
      tests_failed++; $display("FAIL wr_mdc_busy: got %0d/%0d bad cycles want 0/0", o.mdc_bad, o.busy_bad);
    end
    tests_run++;
    if ({o.busy_done, o.mdc_done, o.oe_done} !== 3'b000) begin
      tests_failed++; $display("FAIL wr_end_state: got %b want 000", {o.busy_done, o.mdc_done, o.oe_done});
    end
  endtask

  task automatic test_c22_read();
    obs_t o;
    run_a(32'h6190_0000, 16'h1234, 1'b0, o);
    tests_run++;
    if (o.oebits !== {32'hFFFF_FFFF, 32'hFFFC_0000}) begin
      tests_failed++; $display("FAIL rd_oe: got %h want fffffffffffc0000", o.oebits);
    end
    tests_run++;
    if (o.obits !== {32'hFFFF_FFFF, 32'h6190_0000}) begin
      tests_failed++; $display("FAIL rd_stream: got %h want ffffffff61900000", o.obits);
    end
    tests_run++;
    if (o.done_at !== 257 || o.rd_done !== 16'h1234 || o.rdy_cnt !== 1) begin
      tests_failed++;
      $display("FAIL rd_data: got at %0d rd %h rdy %0d want 257 1234 1", o.done_at, o.rd_done, o.rdy_cnt);
    end
    tests_run++;
    if (o.err_done !== 1'b0) begin
      tests_failed++; $display("FAIL rd_err: got %b want 0", o.err_done);
    end
  endtask

  task automatic test_bad_ta();
    obs_t o;
    run_a(32'h6190_0000, 16'hA5A5, 1'b1, o);
    tests_run++;
    if (o.rd_done !== 16'hA5A5 || o.err_done !== 1'b1) begin
      tests_failed++; $display("FAIL badta: got rd %h err %b want a5a5 1", o.rd_done, o.err_done);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (a_err !== 1'b1) begin
      tests_failed++; $display("FAIL badta_sticky: got %b want 1", a_err);
    end
  endtask

  task automatic test_c45_read();
    obs_t o;
    // ST=00 OP=11: Clause 45 read; also clears the sticky ERR from before.
    run_a(32'h3000_0000, 16'h5A3C, 1'b0, o);
    tests_run++;
    if (o.err_first !== 1'b0) begin
      tests_failed++; $display("FAIL err_clear: got %b want 0", o.err_first);
    end
    tests_run++;
    if (o.oebits !== {32'hFFFF_FFFF, 32'hFFFC_0000} || o.rd_done !== 16'h5A3C || o.rdy_cnt !== 1) begin
      tests_failed++;
      $display("FAIL c45_rd: got oe %h rd %h rdy %0d want fffffffffffc0000 5a3c 1", o.oebits, o.rd_done, o.rdy_cnt);
    end
  endtask

  task automatic test_illegal();
    int bad;
    // Clause 45 frame on a Clause-22-only master.
    @(negedge clk);
    b_tdata = 32'h0000_0000;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    tests_run++;
    if ({b_done, b_err, b_busy, b_mdc} !== 4'b1100) begin
      tests_failed++; $display("FAIL c45off_n1: got %b want 1100", {b_done, b_err, b_busy, b_mdc});
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_busy !== 1'b0 || b_mdc !== 1'b0 || b_done !== 1'b0 || b_err !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL c45off_idle: got %0d bad cycles want 0", bad);
    end
    $display("[TB] txn dut_b T_DATA=00000000 rejected");
    // ST=11 is rejected even with Clause 45 enabled.
    @(negedge clk);
    a_tdata = 32'hC000_0000;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    tests_run++;
    if ({a_done, a_err, a_busy, a_mdc} !== 4'b1100) begin
      tests_failed++; $display("FAIL st1x_n1: got %b want 1100", {a_done, a_err, a_busy, a_mdc});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({a_done, a_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL st1x_n2: got %b want 00", {a_done, a_busy});
    end
    $display("[TB] txn dut_a T_DATA=c0000000 rejected");
  endtask

  task automatic test_pre0();
    logic [31:0] obits;
    int done_at, done_cnt, busy_bad;
    logic busy_after;
    obits = '0; done_at = -1; done_cnt = 0; busy_bad = 0; busy_after = 1'b1;
    @(negedge clk);
    c_tdata = 32'h5192_BEEF;
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    for (int cyc = 1; cyc <= 134; cyc++) begin
      // A second request while busy must be ignored.
      if (cyc == 50) begin c_start = 1'b1; c_tdata = 32'h6000_0000; end
      if (cyc == 52) c_start = 1'b0;
      if (cyc <= 32 * BIT_CYC) begin
        if ((cyc - 1) % BIT_CYC == 0) obits[31 - (cyc - 1) / BIT_CYC] = c_out;
        if (c_busy !== 1'b1) busy_bad++;
      end
      if (c_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (cyc == 131) busy_after = c_busy;
      @(posedge clk); #1;
    end
    tests_run++;
    if (obits !== 32'h5192_BEEF) begin
      tests_failed++; $display("FAIL pre0_stream: got %h want 5192beef", obits);
    end
    tests_run++;
    if (done_at !== 129 || done_cnt !== 1) begin
      tests_failed++; $display("FAIL pre0_done: got at %0d cnt %0d want 129 1", done_at, done_cnt);
    end
    tests_run++;
    if (busy_bad !== 0 || busy_after !== 1'b0) begin
      tests_failed++; $display("FAIL pre0_busy: got bad %0d after %b want 0 0", busy_bad, busy_after);
    end
    $display("[TB] txn dut_c T_DATA=5192beef done_at=%0d", done_at);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int dn;
    logic busy_before;
    logic [15:0] rd_before;
    @(negedge clk);
    a_tdata = 32'h6190_0000;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_in = 1'b1;
    // Advance to cycle 161: first cycle of bit 40.
    repeat (160) @(posedge clk);
    #1;
    busy_before = a_busy;
    rd_before   = a_rd;
    tests_run++;
    if (busy_before !== 1'b1 || rd_before !== 16'h5A3C) begin
      tests_failed++; $display("FAIL mid_hold: got busy %b rd %h want 1 5a3c", busy_before, rd_before);
    end
    #2;
    a_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_mdc, a_out, a_oe, a_rdy, a_done, a_busy, a_err} !== 7'b0 || a_rd !== 16'h0) begin
      tests_failed++;
      $display("FAIL mid_reset: got %b rd %h want 0000000 0000", {a_mdc, a_out, a_oe, a_rdy, a_done, a_busy, a_err}, a_rd);
    end
    dn = 0;
    repeat (2) begin @(posedge clk); #1; if (a_done !== 1'b0) dn++; end
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (a_done !== 1'b0 || a_busy !== 1'b0) dn++; end
    tests_run++;
    if (dn !== 0) begin
      tests_failed++; $display("FAIL mid_nodone: got %0d bad cycles want 0", dn);
    end
    $display("[TB] txn dut_a T_DATA=61900000 aborted by reset");
    run_a(32'h5192_BEEF, 16'h0000, 1'b0, o);
    tests_run++;
    if (o.done_at !== 257 || o.obits !== {32'hFFFF_FFFF, 32'h5192_BEEF} || o.err_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_wr: got at %0d stream %h err %b want 257 ffffffff5192beef 0", o.done_at, o.obits, o.err_done);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_in = 1'b1; b_in = 1'b1; c_in = 1'b1;
    a_tdata = '0; b_tdata = '0; c_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_c22_write();
    test_c22_read();
    test_bad_ta();
    test_c45_read();
    test_illegal();
    test_pre0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
